// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: channel mode encodings and the
// helper that sizes the channel-select field.
package timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Width of a channel index; a single-channel bank still gets one bit.
  function automatic int CHAN_BITS(input int numChannels);
    return (numChannels <= 1) ? 1 : $clog2(numChannels);
  endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Configuration and control bundle for the timer bank. The controller
// (master) drives config writes and start/stop strobes; the bank (slave)
// returns the tick and running flags.
interface timer_bank_if
  import timer_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int COUNT_WIDTH    = 16,
  parameter int PRESCALE_WIDTH = 4
) ();

  localparam int CB = CHAN_BITS(NUM_CHANNELS);

  logic [PRESCALE_WIDTH-1:0] prescale_in;
  logic                      wrEnable_in;
  logic [CB-1:0]             chanSel_in;
  logic [COUNT_WIDTH-1:0]    period_in;
  logic                      mode_in;
  logic [NUM_CHANNELS-1:0]   start_in;
  logic [NUM_CHANNELS-1:0]   stop_in;
  logic [NUM_CHANNELS-1:0]   tick_out;
  logic [NUM_CHANNELS-1:0]   running_out;

  modport master (
    output prescale_in, wrEnable_in, chanSel_in, period_in, mode_in,
           start_in, stop_in,
    input  tick_out, running_out
  );

  modport slave (
    input  prescale_in, wrEnable_in, chanSel_in, period_in, mode_in,
           start_in, stop_in,
    output tick_out, running_out
  );

endinterface

// File: rtl/timer_channel.sv
// One timer channel: holds its own period/mode configuration and a
// down-counter that advances on the shared prescaler strobe.
module timer_channel
  import timer_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   i_strobe,
  input  logic                   i_wr,
  input  logic [COUNT_WIDTH-1:0] i_period,
  input  logic                   i_mode,
  input  logic                   i_start,
  input  logic                   i_stop,
  output logic                   o_tick,
  output logic                   o_running
);

  logic [COUNT_WIDTH-1:0] r_period;
  logic                   r_mode;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_running;
  logic                   r_tick;

  // Config capture plus count/run control; stop beats start beats strobe,
  // and a config write only lands in the period/mode registers so the
  // live count keeps going until its next load.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_period  <= '0;
      r_mode    <= MODE_ONESHOT;
      r_count   <= '0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_wr) begin
        r_period <= i_period;
        r_mode   <= i_mode;
      end
      if (i_stop) begin
        r_running <= 1'b0;
      end else if (i_start) begin
        r_count   <= r_period;
        r_running <= 1'b1;
      end else if (i_strobe && r_running) begin
        if (r_count != '0) begin
          r_count <= r_count - COUNT_WIDTH'(1);
        end else begin
          r_tick <= 1'b1;
          if (r_mode == MODE_PERIODIC) begin
            r_count <= r_period;
          end else begin
            r_running <= 1'b0;
          end
        end
      end
    end
  end

  assign o_tick    = r_tick;
  assign o_running = r_running;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel interval timer: a free-running power-of-two prescaler
// feeds a strobe to NUM_CHANNELS independent down-counting channels.
module timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int COUNT_WIDTH    = 16,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic         clk_in,
  input  logic         reset_in,
  timer_bank_if.slave  bus
);

  localparam int PC_W = 2**PRESCALE_WIDTH - 1;
  localparam int CB   = CHAN_BITS(NUM_CHANNELS);

  logic [PC_W-1:0]         r_pcount;
  logic [PC_W:0]           w_maskWide;
  logic [PC_W-1:0]         w_mask;
  logic                    w_strobe;
  logic [NUM_CHANNELS-1:0] w_wr;
  logic [NUM_CHANNELS-1:0] w_tick;
  logic [NUM_CHANNELS-1:0] w_running;

  // Free-running prescaler; it wraps naturally and is never reset by a
  // channel start, so all channels share one strobe phase.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_pcount <= '0;
    end else begin
      r_pcount <= r_pcount + PC_W'(1);
    end
  end

  // Strobe when the low prescale_in bits are all ones; the mask is built
  // one bit wider so a full-width exponent cannot overflow the shift.
  always_comb begin
    w_maskWide = ((PC_W+1)'(1) << bus.prescale_in) - (PC_W+1)'(1);
    w_mask     = w_maskWide[PC_W-1:0];
    w_strobe   = ((r_pcount & w_mask) == w_mask);
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    // Channel-select values at or beyond NUM_CHANNELS match no channel.
    assign w_wr[c] = bus.wrEnable_in && (bus.chanSel_in == CB'(c));

    timer_channel #(
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_channel (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .i_strobe  (w_strobe),
      .i_wr      (w_wr[c]),
      .i_period  (bus.period_in),
      .i_mode    (bus.mode_in),
      .i_start   (bus.start_in[c]),
      .i_stop    (bus.stop_in[c]),
      .o_tick    (w_tick[c]),
      .o_running (w_running[c])
    );
  end

  assign bus.tick_out    = w_tick;
  assign bus.running_out = w_running;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: a 4-channel build for the main scenarios
// and a 3-channel build for the out-of-range channel-select write.
module tb_timer_bank;
  import timer_pkg::*;

  logic clk_in = 1'b0;
  logic reset_in;

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;

  logic [15:0] tickVec;
  logic [15:0] runVec;
  logic [3:0]  orVec;

  always #5 clk_in = ~clk_in;

  timer_bank_if #(.NUM_CHANNELS(4), .COUNT_WIDTH(16), .PRESCALE_WIDTH(4)) busA ();
  timer_bank_if #(.NUM_CHANNELS(3), .COUNT_WIDTH(16), .PRESCALE_WIDTH(4)) busB ();

  timer_bank #(.NUM_CHANNELS(4), .COUNT_WIDTH(16), .PRESCALE_WIDTH(4)) dutA (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (busA)
  );

  timer_bank #(.NUM_CHANNELS(3), .COUNT_WIDTH(16), .PRESCALE_WIDTH(4)) dutB (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (busB)
  );

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic stepCycle();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic idleInputs();
    busA.prescale_in = '0; busA.wrEnable_in = 1'b0; busA.chanSel_in = '0;
    busA.period_in = '0; busA.mode_in = 1'b0; busA.start_in = '0; busA.stop_in = '0;
    busB.prescale_in = '0; busB.wrEnable_in = 1'b0; busB.chanSel_in = '0;
    busB.period_in = '0; busB.mode_in = 1'b0; busB.start_in = '0; busB.stop_in = '0;
  endtask

  // The reset edge clears the prescaler; cyc counts edges after it.
  task automatic applyReset();
    reset_in = 1'b1;
    stepCycle();
    reset_in = 1'b0;
    cyc = 0;
  endtask

  task automatic writeConfigA(input int ch, input int per, input logic md);
    busA.wrEnable_in = 1'b1;
    busA.chanSel_in  = 2'(ch);
    busA.period_in   = 16'(per);
    busA.mode_in     = md;
    stepCycle();
    busA.wrEnable_in = 1'b0;
  endtask

  task automatic writeConfigB(input int ch, input int per, input logic md);
    busB.wrEnable_in = 1'b1;
    busB.chanSel_in  = 2'(ch);
    busB.period_in   = 16'(per);
    busB.mode_in     = md;
    stepCycle();
    busB.wrEnable_in = 1'b0;
  endtask

  // One-cycle start/stop strobes on the 4-channel build.
  task automatic applyStimulus(input logic [3:0] startMask, input logic [3:0] stopMask);
    busA.start_in = startMask;
    busA.stop_in  = stopMask;
    stepCycle();
    busA.start_in = '0;
    busA.stop_in  = '0;
  endtask

  initial begin
    idleInputs();
    reset_in = 1'b1;
    applyReset();

    checkOutput("reset tickA", 32'(busA.tick_out), 32'h0);
    checkOutput("reset runA", 32'(busA.running_out), 32'h0);
    checkOutput("reset tickB", 32'(busB.tick_out), 32'h0);
    checkOutput("reset runB", 32'(busB.running_out), 32'h0);

    // Periodic ch0, period 3, prescale 0: ticks 4, 8, 12 cycles after start.
    writeConfigA(0, 3, MODE_PERIODIC);
    applyStimulus(4'b0001, 4'b0000);
    tickVec = '0; runVec = '1; orVec = '0;
    for (int i = 1; i <= 12; i++) begin
      stepCycle();
      tickVec[i-1] = busA.tick_out[0];
      runVec[0]    = runVec[0] & busA.running_out[0];
      orVec        = orVec | {busA.tick_out[3:1], 1'b0};
    end
    checkOutput("periodic ch0 ticks", 32'(tickVec[11:0]), 32'h888);
    checkOutput("periodic ch0 running", 32'(runVec[0]), 32'h1);
    checkOutput("idle channels quiet", 32'(orVec), 32'h0);

    // Same-cycle start+stop: stop wins, then a clean restart.
    applyStimulus(4'b0001, 4'b0001);
    checkOutput("start+stop running", 32'(busA.running_out[0]), 32'h0);
    checkOutput("start+stop tick", 32'(busA.tick_out[0]), 32'h0);
    orVec = '0;
    for (int i = 1; i <= 6; i++) begin
      stepCycle();
      orVec = orVec | busA.tick_out | busA.running_out;
    end
    checkOutput("stopped stays quiet", 32'(orVec), 32'h0);
    applyStimulus(4'b0001, 4'b0000);
    checkOutput("restart running", 32'(busA.running_out[0]), 32'h1);
    tickVec = '0;
    for (int i = 1; i <= 8; i++) begin
      stepCycle();
      tickVec[i-1] = busA.tick_out[0];
    end
    checkOutput("restart ticks", 32'(tickVec[7:0]), 32'h88);

    // One-shot ch1, period 2, prescale 2: start on a non-strobe edge whose
    // strobes fall 3, 7, 11 edges later, so the single tick is at edge 11.
    applyReset();
    writeConfigA(1, 2, MODE_ONESHOT);
    busA.prescale_in = 4'd2;
    while (cyc % 4 != 0) stepCycle();
    applyStimulus(4'b0010, 4'b0000);
    tickVec = '0; runVec = '0;
    for (int i = 1; i <= 16; i++) begin
      stepCycle();
      tickVec[i-1] = busA.tick_out[1];
      runVec[i-1]  = busA.running_out[1];
    end
    checkOutput("oneshot ch1 ticks", 32'(tickVec), 32'h0400);
    checkOutput("oneshot ch1 running", 32'(runVec), 32'h03FF);
    busA.prescale_in = '0;

    // Period rewrite on running ch2: old period until the reload at edge 4.
    applyReset();
    writeConfigA(2, 1, MODE_PERIODIC);
    applyStimulus(4'b0100, 4'b0000);
    tickVec = '0;
    for (int i = 1; i <= 16; i++) begin
      busA.wrEnable_in = (i == 3);
      busA.chanSel_in  = 2'd2;
      busA.period_in   = 16'd5;
      busA.mode_in     = MODE_PERIODIC;
      stepCycle();
      tickVec[i-1] = busA.tick_out[2];
    end
    busA.wrEnable_in = 1'b0;
    checkOutput("rewrite ch2 ticks", 32'(tickVec), 32'h820A);

    // Period 0 periodic ch3 ticks every cycle; reset mid-run clears config.
    applyReset();
    writeConfigA(0, 3, MODE_PERIODIC);
    writeConfigA(3, 0, MODE_PERIODIC);
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("p0 first tick", 32'(busA.tick_out[3]), 32'h0);
    tickVec = '0;
    for (int i = 1; i <= 5; i++) begin
      stepCycle();
      tickVec[i-1] = busA.tick_out[3];
    end
    checkOutput("p0 continuous ticks", 32'(tickVec[4:0]), 32'h1F);
    reset_in = 1'b1;
    stepCycle();
    reset_in = 1'b0;
    checkOutput("midrun reset tick", 32'(busA.tick_out), 32'h0);
    checkOutput("midrun reset run", 32'(busA.running_out), 32'h0);
    // Cleared config is period 0 one-shot: one tick one cycle after start.
    applyStimulus(4'b1001, 4'b0000);
    checkOutput("post-reset start run", 32'(busA.running_out), 32'h9);
    checkOutput("post-reset start tick", 32'(busA.tick_out), 32'h0);
    stepCycle();
    checkOutput("post-reset oneshot tick", 32'(busA.tick_out), 32'h9);
    checkOutput("post-reset oneshot run", 32'(busA.running_out), 32'h0);
    stepCycle();
    checkOutput("post-reset no retick", 32'(busA.tick_out), 32'h0);

    // 3-channel build: a write to chanSel 3 must not touch any channel.
    applyReset();
    writeConfigB(0, 1, MODE_PERIODIC);
    writeConfigB(1, 1, MODE_PERIODIC);
    writeConfigB(2, 1, MODE_PERIODIC);
    writeConfigB(3, 7, MODE_ONESHOT);
    busB.start_in = 3'b111;
    stepCycle();
    busB.start_in = '0;
    for (int i = 1; i <= 6; i++) begin
      stepCycle();
      checkOutput($sformatf("oob write tick step%0d", i), 32'(busB.tick_out),
                  (i % 2 == 0) ? 32'h7 : 32'h0);
    end
    checkOutput("oob write running", 32'(busB.running_out), 32'h7);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
